program_loader: RTL
===================

Name: program_loader

Overview:
- Writer side of the CPU program memory: fills instruction memory from a byte stream before the CPU runs.
- Bytes come from the UART receiver as one-cycle strobes. Pairs are assembled big-endian into 16-bit instruction words and written to consecutive memory addresses.
- Loading ends on the halt instruction (opcode 5'b00000) or on memory overflow.
- Holds the CPU in reset while a load is in progress.

Parameters:
- NBITS_O, 11, address width of program memory write port.
- NBITS_D, 16, instruction width; fixed at 16 (two bytes per word).
- CELDAS, 10, number of program memory cells; writes limited to addresses 0..CELDAS-1.

Ports:
- i_clk  input  1  system clock, all logic on rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_Start  input  1  one-cycle pulse: begin (or restart) a load at address 0.
- i_RxData  input  8  received byte, valid when i_RxDone=1.
- i_RxDone  input  1  one-cycle strobe, byte available.
- o_WrEn  output  1  program memory write enable, one cycle per word.
- o_WrAddr  output  NBITS_O  program memory write address.
- o_WrData  output  NBITS_D  instruction word to write.
- o_CpuHold  output  1  high while loading or in error; drives CPU reset.
- o_Done  output  1  level, load ended on halt word.
- o_Error  output  1  level, memory filled without halt word.
- o_WordCount  output  NBITS_O  number of words written in current/last load.

Behaviour:
- Reset values:
  - state IDLE; all outputs 0; internal address 0; high-byte register 0.
  - Reset in any state, including mid-load, returns to IDLE in one cycle. Partial words are discarded.
- States: IDLE, RX_HI, RX_LO, WRITE, DONE, ERROR.
- IDLE: o_CpuHold=0. i_RxDone is ignored. On i_Start: go to RX_HI with addr<=0, o_WordCount<=0, o_Done<=0, o_Error<=0.
- RX_HI: o_CpuHold=1. On i_RxDone: hi<=i_RxData, go to RX_LO.
- RX_LO: o_CpuHold=1. On i_RxDone: word<={hi,i_RxData}, go to WRITE.
- WRITE (exactly one cycle):
  - o_WrEn=1, o_WrAddr=addr, o_WrData=word; o_WordCount increments at the end of this cycle.
  - Next state, in priority order:
    - word[15:11]==5'b00000 (halt) -> DONE.
    - else addr==CELDAS-1 -> ERROR.
    - else addr<=addr+1 -> RX_HI.
  - An i_RxDone arriving during WRITE is not lost:
    - If next state is RX_HI, the byte is stored as hi and the FSM goes to RX_LO instead.
    - If next state is DONE or ERROR, the byte is dropped.
- DONE: o_Done=1, o_CpuHold=0. Stays until i_Start (restart) or reset.
- ERROR: o_Error=1, o_CpuHold=1. Stays until i_Start or reset.
- Latency: o_WrEn asserts the cycle after the edge sampling the low-byte i_RxDone.
- o_WrEn is 0 in every state other than WRITE. o_WrAddr and o_WrData hold their last written values outside WRITE.
- i_Start in any state (RX_HI, RX_LO, WRITE, DONE, ERROR) restarts at address 0 and discards any partial byte.
  - i_Start and i_RxDone in the same cycle: i_Start wins, the byte is discarded.
  - i_Start in WRITE: the write in that cycle still occurs, then the load restarts.
- Address never exceeds CELDAS-1. No write is ever issued to address >= CELDAS.
- Byte order: first received byte is word[15:8].

Test Plan:
- Start, then bytes 10 01, 28 02, 00 00 -> three WrEn pulses: (0,0x1001), (1,0x2802), (2,0x0000). Then o_Done=1, o_CpuHold=0, o_WordCount=3.
- CELDAS=10, 10 words of 0x1801, no halt -> writes to addresses 0..9, then o_Error=1, o_CpuHold=1, o_WordCount=10. An 11th word produces no WrEn.
- Send 0x10, pulse i_Start, send 08 01 00 00 -> first write is (0,0x0801). The stale 0x10 is never used; o_Done after 2 words.
- Mid-load i_reset after 1 word plus 1 byte -> next cycle all outputs 0, state IDLE. Further bytes ignored until i_Start.
- i_RxDone=1 with byte 0x18 during the WRITE cycle of non-halt word 0x2003, then byte 0x05 -> second write (1,0x1805), no byte lost.
- After DONE, i_Start then 00 00 -> o_Done drops on restart; single write (0,0x0000); o_Done=1, o_WordCount=1.

Source files
------------

// File: rtl/program_loader.sv
// Program memory writer: assembles big-endian byte pairs from the UART into
// instruction words and stores them at consecutive addresses, holding the CPU meanwhile.
module program_loader #(
  parameter int NBITS_O = 11,
  parameter int NBITS_D = 16,
  parameter int CELDAS  = 10
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_Start,
  input  logic [7:0]         i_RxData,
  input  logic               i_RxDone,
  output logic               o_WrEn,
  output logic [NBITS_O-1:0] o_WrAddr,
  output logic [NBITS_D-1:0] o_WrData,
  output logic               o_CpuHold,
  output logic               o_Done,
  output logic               o_Error,
  output logic [NBITS_O-1:0] o_WordCount
);

  typedef enum logic [2:0] {
    IDLE,
    RX_HI,
    RX_LO,
    WRITE,
    DONE,
    ERROR
  } state_t;

  localparam logic [NBITS_O-1:0] LAST_ADDR = NBITS_O'(CELDAS - 1);

  state_t               state_q, state_d;
  logic [NBITS_O-1:0]   addr_q, addr_d;
  logic [7:0]           hi_q, hi_d;
  logic [NBITS_O-1:0]   wrAddr_q, wrAddr_d;
  logic [NBITS_D-1:0]   wrData_q, wrData_d;
  logic [NBITS_O-1:0]   count_q, count_d;
  logic                 wrEn_q, cpuHold_q, done_q, error_q;
  logic                 isHalt;

  // The halt opcode lives in the top five bits of the word being written.
  assign isHalt = (wrData_q[NBITS_D-1 -: 5] == 5'b00000);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    hi_d     = hi_q;
    wrAddr_d = wrAddr_q;
    wrData_d = wrData_q;
    count_d  = count_q;

    case (state_q)
      IDLE: ;
      RX_HI: begin
        if (i_RxDone) begin
          hi_d    = i_RxData;
          state_d = RX_LO;
        end
      end
      RX_LO: begin
        if (i_RxDone) begin
          wrData_d = {hi_q, i_RxData};
          wrAddr_d = addr_q;
          state_d  = WRITE;
        end
      end
      WRITE: begin
        count_d = count_q + 1'b1;
        if (isHalt) begin
          state_d = DONE;
        end else if (addr_q == LAST_ADDR) begin
          state_d = ERROR;
        end else begin
          addr_d = addr_q + 1'b1;
          // A byte landing during the write cycle is the next high byte.
          if (i_RxDone) begin
            hi_d    = i_RxData;
            state_d = RX_LO;
          end else begin
            state_d = RX_HI;
          end
        end
      end
      DONE: ;
      ERROR: ;
      default: state_d = IDLE;
    endcase

    if (i_Start) begin
      state_d = RX_HI;
      addr_d  = '0;
      count_d = '0;
      hi_d    = '0;
    end
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      hi_q      <= '0;
      wrAddr_q  <= '0;
      wrData_q  <= '0;
      count_q   <= '0;
      wrEn_q    <= 1'b0;
      cpuHold_q <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      hi_q      <= hi_d;
      wrAddr_q  <= wrAddr_d;
      wrData_q  <= wrData_d;
      count_q   <= count_d;
      wrEn_q    <= (state_d == WRITE);
      cpuHold_q <= (state_d == RX_HI) || (state_d == RX_LO) ||
                   (state_d == WRITE) || (state_d == ERROR);
      done_q    <= (state_d == DONE);
      error_q   <= (state_d == ERROR);
    end
  end

  assign o_WrEn      = wrEn_q;
  assign o_WrAddr    = wrAddr_q;
  assign o_WrData    = wrData_q;
  assign o_CpuHold   = cpuHold_q;
  assign o_Done      = done_q;
  assign o_Error     = error_q;
  assign o_WordCount = count_q;

endmodule
